// File: rtl/rsp_reorder_buffer.sv
// rsp_reorder_buffer
//
// Restores per-original-ID ordering of read responses. An upstream allocator
// hands out unique IDs {row, col}: one row per original AXI ID, with columns
// issued in sequence. Responses come back tagged with the unique ID in any
// order. They are parked in an N x N slot array and released per row in
// column order, with the original ID restored. When a row has no outstanding
// transactions left, it is handed back to the allocator.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   alloc_valid/uid/id        unique ID issued upstream; binds orig ID to row
//   rsp_valid/ready/uid       response input handshake
//   rsp_data/rsp_resp         response payload
//   out_valid/ready           reordered output handshake
//   out_id/data/resp          restored original ID and payload
//   free_valid/free_row       one-cycle pulse releasing a row
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and payload stable until the transfer. rsp_ready
// depends only on rsp_uid and slot state, never on rsp_valid.
module rsp_reorder_buffer #(
    parameter int ID_WIDTH        = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 16,
    localparam int IDX_W          = $clog2(MAX_OUTSTANDING),
    localparam int UW             = 2 * IDX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic [UW-1:0]         alloc_uid,
    input  logic [ID_WIDTH-1:0]   alloc_id,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [UW-1:0]         rsp_uid,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic [1:0]            rsp_resp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  free_valid,
    output logic [IDX_W-1:0]      free_row
);

    localparam int N     = MAX_OUTSTANDING;
    localparam int NS    = N * N;
    localparam int CNT_W = IDX_W + 1;

    // Slot storage, indexed directly by the unique ID {row, col}.
    logic                  slot_valid_q [NS];
    logic [DATA_WIDTH-1:0] slot_data_q  [NS];
    logic [1:0]            slot_resp_q  [NS];

    // Per-row state.
    logic [ID_WIDTH-1:0]   row_id_q [N];
    logic [IDX_W-1:0]      head_q   [N];
    logic [CNT_W-1:0]      count_q  [N];
    logic [CNT_W-1:0]      count_d  [N];

    // Round-robin pointer: the row where the next search starts.
    logic [IDX_W-1:0]      rr_q;

    logic                  out_valid_q;
    logic [ID_WIDTH-1:0]   out_id_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [1:0]            out_resp_q;
    logic [IDX_W-1:0]      out_row_q;

    logic                  free_valid_q, free_valid_d;
    logic [IDX_W-1:0]      free_row_q, free_row_d;

    logic [IDX_W-1:0]      alloc_row;
    logic                  alloc_ok;
    logic                  rsp_fire;
    logic                  out_fire;
    logic [N-1:0]          eligible;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_row;
    logic [UW-1:0]         grant_uid;
    logic                  load;

    // The allocator's column is trusted; it is not cross-checked here.
    logic                  unused_alloc_col;
    assign unused_alloc_col = ^alloc_uid[IDX_W-1:0];

    assign alloc_row = alloc_uid[UW-1:IDX_W];
    assign alloc_ok  = alloc_valid && (count_q[alloc_row] != CNT_W'(N));
    assign rsp_ready = !slot_valid_q[rsp_uid];
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign out_fire  = out_valid_q && out_ready;

    // A row is eligible when its head slot is filled. The slot sitting in the
    // output register has already been cleared and its head advanced, so it
    // can never be picked twice.
    always_comb begin
        eligible = '0;
        for (int r = 0; r < N; r++) begin
            eligible[r] = slot_valid_q[{IDX_W'(r), head_q[r]}];
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_row   = '0;
        for (int i = 0; i < N; i++) begin
            if (!grant_found && eligible[rr_q + IDX_W'(i)]) begin
                grant_found = 1'b1;
                grant_row   = rr_q + IDX_W'(i);
            end
        end
    end

    assign grant_uid = {grant_row, head_q[grant_row]};
    assign load      = grant_found && (!out_valid_q || out_ready);

    // Outstanding counts: an alloc and a drain hitting the same row cancel.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            count_d[r] = count_q[r];
            if (alloc_ok && alloc_row == IDX_W'(r) &&
                !(out_fire && out_row_q == IDX_W'(r))) begin
                count_d[r] = count_q[r] + CNT_W'(1);
            end else if (out_fire && out_row_q == IDX_W'(r) &&
                         !(alloc_ok && alloc_row == IDX_W'(r))) begin
                count_d[r] = count_q[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        free_valid_d = 1'b0;
        free_row_d   = '0;
        if (out_fire && count_q[out_row_q] == CNT_W'(1) &&
            !(alloc_ok && alloc_row == out_row_q)) begin
            free_valid_d = 1'b1;
            free_row_d   = out_row_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                slot_valid_q[s] <= 1'b0;
            end
            for (int r = 0; r < N; r++) begin
                row_id_q[r] <= '0;
                head_q[r]   <= '0;
                count_q[r]  <= '0;
            end
            rr_q         <= '0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_data_q   <= '0;
            out_resp_q   <= '0;
            out_row_q    <= '0;
            free_valid_q <= 1'b0;
            free_row_q   <= '0;
        end else begin
            // A response only lands in an empty slot and a load only takes a
            // full one, so these two writes never target the same slot.
            if (rsp_fire) begin
                slot_valid_q[rsp_uid] <= 1'b1;
            end
            if (load) begin
                slot_valid_q[grant_uid] <= 1'b0;
                head_q[grant_row]       <= head_q[grant_row] + 1'b1;
                rr_q                    <= grant_row + 1'b1;
                out_valid_q             <= 1'b1;
                out_id_q                <= row_id_q[grant_row];
                out_data_q              <= slot_data_q[grant_uid];
                out_resp_q              <= slot_resp_q[grant_uid];
                out_row_q               <= grant_row;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            for (int r = 0; r < N; r++) begin
                count_q[r] <= count_d[r];
            end
            if (alloc_ok) begin
                row_id_q[alloc_row] <= alloc_id;
            end
            free_valid_q <= free_valid_d;
            free_row_q   <= free_row_d;
        end
    end

    // Payload storage needs no reset: it is only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            slot_data_q[rsp_uid] <= rsp_data;
            slot_resp_q[rsp_uid] <= rsp_resp;
        end
    end

    // Allocating into a row that already has N outstanding is a protocol error.
    always_ff @(posedge clk) begin
        if (!rst && alloc_valid) begin
            assert (count_q[alloc_row] != CNT_W'(N));
        end
    end

    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_data   = out_data_q;
    assign out_resp   = out_resp_q;
    assign free_valid = free_valid_q;
    assign free_row   = free_row_q;

endmodule

// File: tb/tb_rsp_reorder_buffer.sv
// Directed bench for rsp_reorder_buffer with N=4 (UW=4, IDX_W=2).
module tb_rsp_reorder_buffer;

    localparam int ID_WIDTH   = 4;
    localparam int DATA_WIDTH = 32;
    localparam int N          = 4;
    localparam int IDX_W      = 2;
    localparam int UW         = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  alloc_valid;
    logic [UW-1:0]         alloc_uid;
    logic [ID_WIDTH-1:0]   alloc_id;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [UW-1:0]         rsp_uid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_resp;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_resp;
    logic                  free_valid;
    logic [IDX_W-1:0]      free_row;

    int total = 0;
    int bad   = 0;

    rsp_reorder_buffer #(
        .ID_WIDTH       (ID_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_OUTSTANDING(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_valid(alloc_valid),
        .alloc_uid  (alloc_uid),
        .alloc_id   (alloc_id),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_uid    (rsp_uid),
        .rsp_data   (rsp_data),
        .rsp_resp   (rsp_resp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_data   (out_data),
        .out_resp   (out_resp),
        .free_valid (free_valid),
        .free_row   (free_row)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [UW-1:0] uid, input logic [ID_WIDTH-1:0] id);
        alloc_valid = 1'b1;
        alloc_uid   = uid;
        alloc_id    = id;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic drive_rsp(input logic [UW-1:0] uid, input logic [DATA_WIDTH-1:0] data,
                             input logic [1:0] resp);
        rsp_valid = 1'b1;
        rsp_uid   = uid;
        rsp_data  = data;
        rsp_resp  = resp;
    endtask

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b0;
        alloc_uid   = '0;
        alloc_id    = '0;
        rsp_valid   = 1'b0;
        rsp_uid     = '0;
        rsp_data    = '0;
        rsp_resp    = '0;
        out_ready   = 1'b1;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_free_valid", free_valid, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        chk("rst_rsp_ready", rsp_ready, 1);

        // Single transaction, latency k+2, then free of row 0
        do_alloc(4'h0, 4'h5);
        drive_rsp(4'h0, 32'hA, 2'd0);
        #1;
        chk("t1_rsp_ready", rsp_ready, 1);
        step();
        rsp_valid = 1'b0;
        chk("t1_k1_out_valid", out_valid, 0);
        step();
        chk("t1_k2_out_valid", out_valid, 1);
        chk("t1_out_id", out_id, 5);
        chk("t1_out_data", out_data, 32'hA);
        step();
        chk("t1_out_valid_after", out_valid, 0);
        chk("t1_free_valid", free_valid, 1);
        chk("t1_free_row", free_row, 0);
        step();
        chk("t1_free_pulse_end", free_valid, 0);

        // Out-of-order responses on row 1
        do_alloc(4'h4, 4'h3);
        do_alloc(4'h5, 4'h3);
        drive_rsp(4'h5, 32'hB, 2'd0);
        step();
        drive_rsp(4'h4, 32'hC, 2'd0);
        step();
        rsp_valid = 1'b0;
        chk("t2_wait_out_valid", out_valid, 0);
        step();
        chk("t2_first_valid", out_valid, 1);
        chk("t2_first_data", out_data, 32'hC);
        chk("t2_first_id", out_id, 3);
        step();
        chk("t2_second_valid", out_valid, 1);
        chk("t2_second_data", out_data, 32'hB);
        chk("t2_second_id", out_id, 3);
        chk("t2_no_early_free", free_valid, 0);
        step();
        chk("t2_drained", out_valid, 0);
        chk("t2_free_valid", free_valid, 1);
        chk("t2_free_row", free_row, 1);

        // Backpressure: payload held for 5 cycles, single output on release
        out_ready = 1'b0;
        do_alloc(4'h8, 4'h7);
        drive_rsp(4'h8, 32'h1234_5678, 2'd2);
        step();
        rsp_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_id", out_id, 7);
            chk("t3_hold_data", out_data, 32'h1234_5678);
            chk("t3_hold_resp", out_resp, 2);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("t3_single_output", out_valid, 0);
        chk("t3_free_valid", free_valid, 1);
        chk("t3_free_row", free_row, 2);
        step();
        chk("t3_free_pulse_end", free_valid, 0);

        // Round robin across rows 0 and 2 (heads are at column 1 in both)
        out_ready = 1'b0;
        do_alloc(4'h1, 4'hA);
        do_alloc(4'h2, 4'hA);
        do_alloc(4'h9, 4'hC);
        do_alloc(4'hA, 4'hC);
        drive_rsp(4'h1, 32'h100, 2'd0);
        step();
        drive_rsp(4'h2, 32'h101, 2'd0);
        step();
        drive_rsp(4'h9, 32'h200, 2'd0);
        step();
        drive_rsp(4'hA, 32'h201, 2'd0);
        step();
        rsp_valid = 1'b0;
        step();
        chk("t4_o1_valid", out_valid, 1);
        chk("t4_o1_id", out_id, 4'hA);
        chk("t4_o1_data", out_data, 32'h100);
        out_ready = 1'b1;
        step();
        chk("t4_o2_id", out_id, 4'hC);
        chk("t4_o2_data", out_data, 32'h200);
        step();
        chk("t4_o3_id", out_id, 4'hA);
        chk("t4_o3_data", out_data, 32'h101);
        step();
        chk("t4_o4_id", out_id, 4'hC);
        chk("t4_o4_data", out_data, 32'h201);
        chk("t4_free0_valid", free_valid, 1);
        chk("t4_free0_row", free_row, 0);
        step();
        chk("t4_drained", out_valid, 0);
        chk("t4_free2_valid", free_valid, 1);
        chk("t4_free2_row", free_row, 2);

        // Reset mid-stream with a loaded output register
        out_ready = 1'b0;
        do_alloc(4'hC, 4'h1);
        drive_rsp(4'hC, 32'h77, 2'd1);
        step();
        rsp_valid = 1'b0;
        step();
        chk("t5_pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_free_valid", free_valid, 0);
        chk("t5_rst_out_data", out_data, 0);
        step();
        rst = 1'b0;

        // Row 0 from head 0: fill all four columns, duplicate held off
        do_alloc(4'h0, 4'h6);
        do_alloc(4'h1, 4'h6);
        do_alloc(4'h2, 4'h6);
        do_alloc(4'h3, 4'h6);
        drive_rsp(4'h0, 32'h30, 2'd0);
        #1;
        chk("t6_first_after_rst_ready", rsp_ready, 1);
        step();
        drive_rsp(4'h1, 32'h31, 2'd0);
        step();
        drive_rsp(4'h2, 32'h32, 2'd0);
        step();
        drive_rsp(4'h3, 32'h33, 2'd0);
        step();
        drive_rsp(4'h1, 32'hFF, 2'd3);
        #1;
        chk("t6_dup_rsp_ready", rsp_ready, 0);
        step();
        rsp_valid = 1'b0;
        chk("t6_o0_valid", out_valid, 1);
        chk("t6_o0_id", out_id, 6);
        chk("t6_o0_data", out_data, 32'h30);
        out_ready = 1'b1;
        step();
        chk("t6_o1_data", out_data, 32'h31);
        chk("t6_o1_resp", out_resp, 0);
        step();
        chk("t6_o2_data", out_data, 32'h32);
        step();
        chk("t6_o3_data", out_data, 32'h33);
        chk("t6_o3_valid", out_valid, 1);
        step();
        chk("t6_drained", out_valid, 0);
        chk("t6_free_valid", free_valid, 1);
        chk("t6_free_row", free_row, 0);

        // Column 0 again: head wrapped 3 -> 0
        do_alloc(4'h0, 4'h9);
        drive_rsp(4'h0, 32'h40, 2'd1);
        #1;
        chk("t6_wrap_rsp_ready", rsp_ready, 1);
        step();
        rsp_valid = 1'b0;
        chk("t6_wrap_k1_valid", out_valid, 0);
        step();
        chk("t6_wrap_valid", out_valid, 1);
        chk("t6_wrap_id", out_id, 9);
        chk("t6_wrap_data", out_data, 32'h40);
        chk("t6_wrap_resp", out_resp, 1);
        step();
        chk("t6_wrap_free_valid", free_valid, 1);
        chk("t6_wrap_free_row", free_row, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsp_reorder_buffer.md
RSP_REORDER_BUFFER -- requirements
Module: rsp_reorder_buffer

Interface
REQ-001 Parameter ID_WIDTH, 4, original AXI ID width.
REQ-002 Parameter DATA_WIDTH, 32, read data width.
REQ-003 Parameter MAX_OUTSTANDING, 16, rows and columns per row (N, power of 2); IDX_W = log2(N), unique ID width UW = 2*IDX_W, {row, col}.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 alloc_valid  in  1  one-cycle pulse: a unique ID was issued upstream.
REQ-007 alloc_uid  in  UW  issued unique ID {row, col}.
REQ-008 alloc_id  in  ID_WIDTH  original ID bound to alloc_uid row.
REQ-009 rsp_valid / rsp_ready  in / out  1 / 1  response input handshake.
REQ-010 rsp_uid  in  UW  unique ID tag of the response.
REQ-011 rsp_data / rsp_resp  in  DATA_WIDTH / 2  response payload.
REQ-012 out_valid / out_ready  out / in  1 / 1  reordered output handshake.
REQ-013 out_id / out_data / out_resp  out  ID_WIDTH / DATA_WIDTH / 2  restored original ID and payload.
REQ-014 free_valid / free_row  out / out  1 / IDX_W  one-cycle pulse releasing a row back to the ID allocator.

Function
REQ-015 Storage: N*N slots, each holding valid bit, data, resp; per-row state: bound orig ID, head column pointer (IDX_W), outstanding count (IDX_W+1 bits).
REQ-016 alloc_valid: row_id[row] <= alloc_id; count[row] increments; alloc_uid col is not checked.
REQ-017 Count saturates at N; alloc at count==N is a protocol error (sim assertion), state otherwise unchanged.
REQ-018 rsp_ready = NOT slot_valid[rsp_uid]; combinational from rsp_uid and slot state only, never from rsp_valid.
REQ-019 rsp handshake (rsp_valid AND rsp_ready): slot[rsp_uid] <= {1, rsp_data, rsp_resp}.
REQ-020 Row r is eligible when slot_valid[r][head[r]] = 1 and that slot is not currently loaded in the output register.
REQ-021 Output register loads when empty or consumed this cycle (out_valid AND out_ready); selects one eligible row round-robin, starting from the row after the last granted row (reset pointer: row 0 first).
REQ-022 On load: out_id <= row_id[r], out_data/out_resp <= slot payload, out_valid <= 1, slot valid cleared, head[r] <= (head[r]+1) mod N (wraps N-1 -> 0).
REQ-023 Latency: rsp handshake in cycle k -> out_valid earliest in cycle k+2.
REQ-024 While out_valid=1 and out_ready=0: out_valid, out_id, out_data, out_resp held stable.
REQ-025 Output handshake of row r: count[r] decrements; simultaneous alloc to same row leaves count unchanged.
REQ-026 Count of row r reaching 0 with no simultaneous alloc to r: free_valid=1, free_row=r in the next cycle, for one cycle.
REQ-027 Head pointers are not cleared on free; column sequence per row continues modulo N across row reuse.
REQ-028 Response to a slot already valid: held off by rsp_ready=0 until the slot drains.
REQ-029 Back-to-back: with out_ready=1 and eligible rows, one output per cycle.

Reset
REQ-030 Asserting rst at any time, including mid-transfer, immediately clears all slot valid bits, counts, heads, round-robin pointer, row IDs, out_valid, out_id, out_data, out_resp, free_valid, free_row to 0.
REQ-031 rsp_ready is 1 for every rsp_uid while rst is deasserted and no slots are valid; in-flight data is discarded on reset.

Verification (N=4, UW=4)
REQ-032 Reset asserted mid-stream with out_valid=1 -> out_valid, free_valid 0 that cycle; first response after release accepted with rsp_ready=1.
REQ-033 alloc uid 0x0 id 5; rsp uid 0x0 data 0xA in cycle k -> out_valid in k+2, out_id 5, out_data 0xA; after handshake free_valid=1, free_row=0 for one cycle.
REQ-034 alloc 0x4, 0x5 id 3; rsp 0x5 data 0xB, then 0x4 data 0xC -> outputs 0xC then 0xB, both out_id 3; free_row=1 after second.
REQ-035 out_ready held 0 for 5 cycles with out_valid=1 -> payload constant all 5 cycles; single output on release.
REQ-036 Rows 0 and 2 each hold two ready in-order responses, out_ready=1 -> output row order 0,2,0,2.
REQ-037 Row 0 ids 0x0,0x1,0x2,0x3 then 0x0 after drain, responses in order -> five outputs in order, head wraps 3->0; duplicate rsp uid 0x1 while slot full -> rsp_ready=0.
